// File: rtl/vga_pkg.sv
// Shared VGA timing constants, decoder state encoding and colour layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // VGA_COLOR / pix_color bit layout
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_edge_sampler.sv
// Registers HS/VS/BLANK_N on pixel_en and flags falling edges between samples.
// Latency: edge pulses are combinational on the sampling cycle.
// Backpressure: none; non-pixel_en cycles hold history and never flag an edge.
module vga_edge_sampler (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic pixel_en,
    input  logic hs,
    input  logic vs,
    input  logic blank_n,
    output logic hs_fall,
    output logic vs_fall,
    output logic bl_fall
);

    logic hs_q;
    logic vs_q;
    logic bl_q;

    // Idle levels at reset so the first real sample cannot look like an edge
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            bl_q <= 1'b0;
        end else if (pixel_en) begin
            hs_q <= hs;
            vs_q <= vs;
            bl_q <= blank_n;
        end
    end

    assign hs_fall = pixel_en & hs_q & ~hs;
    assign vs_fall = pixel_en & vs_q & ~vs;
    assign bl_fall = pixel_en & bl_q & ~blank_n;

endmodule

// File: rtl/vga_frame_decoder.sv
// Rebuilds pixel coordinates from VGA sync/blank, strobes active pixels, tracks frame lock.
// Latency: one CLOCK_50 cycle from a pixel_en sample to pix_valid/frame pulses.
// Backpressure: none; the sink must accept one strobe per pixel_en.
module vga_frame_decoder #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          pixel_en,
    input  logic          VGA_HS,
    input  logic          VGA_VS,
    input  logic          VGA_BLANK_N,
    input  logic [23:0]   VGA_COLOR,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [23:0]   pix_color,
    output logic          frame_start,
    output logic          frame_done,
    output logic          locked,
    output logic          err_overrun,
    output logic          err_short
);
    import vga_pkg::*;

    localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);

    state_e        state_q;
    state_e        state_d;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          frame_ok;

    logic hs_fall;
    logic vs_fall;
    logic bl_fall;

    vga_edge_sampler u_sampler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .pixel_en (pixel_en),
        .hs       (VGA_HS),
        .vs       (VGA_VS),
        .blank_n  (VGA_BLANK_N),
        .hs_fall  (hs_fall),
        .vs_fall  (vs_fall),
        .bl_fall  (bl_fall)
    );

    // While searching, counters run but nothing is reported or flagged
    logic tracking;
    logic pix_sample;
    logic overrun_hit;
    logic short_hit;
    logic frame_good;

    assign tracking    = (state_q != SEARCH);
    assign pix_sample  = pixel_en & VGA_BLANK_N & tracking;
    assign overrun_hit = pix_sample & ((x_cnt >= X_END) | (y_cnt >= Y_END));
    assign short_hit   = bl_fall & tracking & (x_cnt != X_END);
    assign frame_good  = tracking & frame_ok & (y_cnt == Y_END);
    assign locked      = (state_q == LOCKED);

    always_comb begin
        state_d = state_q;
        if (vs_fall) begin
            case (state_q)
                SEARCH:  state_d = LOCKING;
                LOCKING: if (frame_good) state_d = LOCKED;
                LOCKED:  if (!frame_good) state_d = LOCKING;
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= SEARCH;
            x_cnt       <= '0;
            y_cnt       <= '0;
            frame_ok    <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_color   <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            if (pixel_en) begin
                if (hs_fall)
                    x_cnt <= '0;
                else if (VGA_BLANK_N && x_cnt != '1)
                    x_cnt <= x_cnt + 1'b1;

                if (vs_fall)
                    y_cnt <= '0;
                else if (bl_fall && y_cnt != '1)
                    y_cnt <= y_cnt + 1'b1;
            end

            if (pix_sample && !overrun_hit) begin
                pix_valid <= 1'b1;
                pix_x     <= x_cnt;
                pix_y     <= y_cnt;
                pix_color <= VGA_COLOR;
            end

            if (overrun_hit) err_overrun <= 1'b1;
            if (short_hit)   err_short   <= 1'b1;

            // Judge the ending frame with the pre-clear y_cnt, then arm for the next
            if (vs_fall) begin
                frame_start <= 1'b1;
                frame_done  <= frame_good;
                frame_ok    <= 1'b1;
            end else if (overrun_hit || short_hit) begin
                frame_ok    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_decoder.sv
// Directed frame sequence with random pixel_en gaps, idle-cycle glitches and colours,
// checked against a frame-level reference model.
module tb_vga_frame_decoder;
    import vga_pkg::*;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int XW    = 10;
    localparam int YW    = 9;
    localparam int H_FP  = 2;
    localparam int H_SY  = 3;
    localparam int H_BP  = 3;
    localparam int H_TOT = H + H_FP + H_SY + H_BP;
    localparam int V_FP  = 1;
    localparam int V_SY  = 2;
    localparam int V_BP  = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pixel_en = 1'b0;
    logic          hs = 1'b1;
    logic          vs = 1'b1;
    logic          bl = 1'b0;
    logic [23:0]   col = '0;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [23:0]   pix_color;
    logic          frame_start;
    logic          frame_done;
    logic          locked;
    logic          err_overrun;
    logic          err_short;

    always #5 clk = ~clk;

    vga_frame_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .pixel_en    (pixel_en),
        .VGA_HS      (hs),
        .VGA_VS      (vs),
        .VGA_BLANK_N (bl),
        .VGA_COLOR   (col),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .locked      (locked),
        .err_overrun (err_overrun),
        .err_short   (err_short)
    );

    int checks = 0;
    int errors = 0;
    logic [XW+YW+23:0] exp_q[$];
    int n_fs = 0;
    int n_fd = 0;
    int n_strobe = 0;
    logic [XW-1:0] last_x = '0;
    logic [YW-1:0] last_y = '0;
    logic vs_lvl = 1'b1;

    // Reference model: decoder tracking/lock status and sticky errors, per frame
    bit m_track = 1'b0;
    bit m_locked = 1'b0;
    bit m_ovr = 1'b0;
    bit m_short = 1'b0;
    bit m_bad = 1'b0;
    int m_nstrobe = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({pix_valid, pix_x, pix_y, pix_color, frame_start, frame_done,
                    locked, err_overrun, err_short});
    endfunction

    // Look at the outputs produced by the previous rising edge
    task automatic observe();
        @(negedge clk);
        if (pix_valid === 1'b1) begin
            n_strobe++;
            last_x = pix_x;
            last_y = pix_y;
            chk("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                chk("strobe_pixel", 64'({pix_x, pix_y, pix_color}), 64'(exp_q.pop_front()));
        end
        if (frame_start === 1'b1) n_fs++;
        if (frame_done === 1'b1) n_fd++;
    endtask

    task automatic drive(input bit pe, input bit h, input bit v, input bit b, input logic [23:0] c);
        observe();
        pixel_en = pe;
        hs = h;
        vs = v;
        bl = b;
        col = c;
    endtask

    // Random idle cycles with garbage inputs, then one real sample
    task automatic sample(input bit h, input bit v, input bit b, input logic [23:0] c);
        logic [26:0] g;
        int gaps;
        gaps = $urandom_range(2, 1);
        for (int i = 0; i < gaps; i++) begin
            g = 27'($urandom);
            drive(1'b0, g[0], g[1], g[2], g[26:3]);
        end
        drive(1'b1, h, v, b, c);
    endtask

    task automatic send_line(input int n_act, input bit vs_new, input int row, input bit ramp);
        logic [23:0] cols [H_TOT];
        bit h;
        bit v;
        for (int p = 0; p < H_TOT; p++) begin
            if (p < n_act && ramp)
                cols[p] = rgb_t'{r: 8'(p), g: 8'(row), b: 8'hA5};
            else
                cols[p] = 24'($urandom);
        end
        if (m_track && n_act > 0) begin
            for (int p = 0; p < n_act; p++) begin
                if (p < H && row < V) begin
                    exp_q.push_back({XW'(p), YW'(row), cols[p]});
                    m_nstrobe++;
                end else begin
                    m_ovr = 1'b1;
                    m_bad = 1'b1;
                end
            end
            if (n_act != H) begin
                m_short = 1'b1;
                m_bad = 1'b1;
            end
        end
        for (int p = 0; p < H_TOT; p++) begin
            h = !(p >= H + H_FP && p < H + H_FP + H_SY);
            v = (p >= H + H_FP) ? vs_new : vs_lvl;
            sample(h, v, (p < n_act), cols[p]);
        end
        vs_lvl = vs_new;
    endtask

    task automatic mid_reset(input string name);
        observe();
        reset = 1'b1;
        observe();
        chk({name, "_reset_outputs"}, all_outputs(), 64'd0);
        reset = 1'b0;
        m_track = 1'b0;
        m_locked = 1'b0;
        m_ovr = 1'b0;
        m_short = 1'b0;
        m_bad = 1'b1;
    endtask

    task automatic send_frame(input string name, input int n_lines, input int long_row,
                              input bit ramp, input int rst_row);
        int fs0;
        int fd0;
        int st0;
        bit good;
        fs0 = n_fs;
        fd0 = n_fd;
        st0 = n_strobe;
        m_nstrobe = 0;
        for (int r = 0; r < n_lines; r++) begin
            send_line((r == long_row) ? H + 1 : H, 1'b1, r, ramp);
            if (r == rst_row) mid_reset(name);
        end
        for (int l = 0; l < V_FP; l++) send_line(0, 1'b1, 0, 1'b0);
        for (int l = 0; l < V_SY; l++) send_line(0, 1'b0, 0, 1'b0);
        for (int l = 0; l < V_BP; l++) send_line(0, 1'b1, 0, 1'b0);
        good = m_track && !m_bad && (n_lines == V);
        if (!m_track) begin
            m_track = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_locked = good;
        end
        chk({name, "_frame_start"}, 64'(n_fs - fs0), 64'd1);
        chk({name, "_frame_done"}, 64'(n_fd - fd0), 64'(good));
        chk({name, "_strobes"}, 64'(n_strobe - st0), 64'(m_nstrobe));
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_locked"}, 64'(locked), 64'(m_locked));
        chk({name, "_err_overrun"}, 64'(err_overrun), 64'(m_ovr));
        chk({name, "_err_short"}, 64'(err_short), 64'(m_short));
        m_bad = 1'b0;
    endtask

    initial begin
        int fs0;
        reset = 1'b1;
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
        observe();
        chk("reset_outputs", all_outputs(), 64'd0);
        reset = 1'b0;

        fs0 = n_fs;
        repeat (10) sample(1'b1, 1'b1, 1'b0, 24'($urandom));
        chk("idle_no_frame_start", 64'(n_fs - fs0), 64'd0);
        chk("idle_outputs", all_outputs(), 64'd0);

        send_frame("search", V, -1, 1'b0, -1);
        send_frame("lock", V, -1, 1'b0, -1);
        chk("lock_strobe_count", 64'(m_nstrobe), 64'(H * V));
        send_frame("ramp", V, -1, 1'b1, -1);
        chk("ramp_last_x", 64'(last_x), 64'(H - 1));
        chk("ramp_last_y", 64'(last_y), 64'(V - 1));
        send_frame("short_frame", V - 1, -1, 1'b0, -1);
        send_frame("relock1", V, -1, 1'b0, -1);
        send_frame("overrun", V, 3, 1'b0, -1);
        send_frame("relock2", V, -1, 1'b1, -1);
        send_frame("reset_mid", V, -1, 1'b0, 3);
        send_frame("after_reset", V, -1, 1'b0, -1);
        send_frame("steady", V, -1, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
